// File: rtl/bias_accum_pkg.sv
// -----------------------------------------------------------------------------
// bias_accum_pkg
// Shared definitions for the bias/accumulate output stage:
//   - DATA_W           : signed width of partials, bias and results (18)
//   - lane_lsb()       : bit offset of a lane inside a packed lane vector
//   - sat_to_dataw()   : clamp a wide signed sum to DATA_W, with a flag
//   - state_t          : stage FSM states (ACCUM / FINAL / HOLD)
// -----------------------------------------------------------------------------
package bias_accum_pkg;

    localparam int DATA_W   = 18;
    // Width at which sums are handed to the saturation helper; any
    // accumulator width up to SAT_IN_W-1 can be clamped by sign extension.
    localparam int SAT_IN_W = 64;

    localparam logic signed [SAT_IN_W-1:0] SAT_MAX = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -SAT_MAX - 64'sd1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FINAL = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic              sat;
    } sat_res_t;

    // Bit offset of lane 'lane' in a vector packed as lane i at
    // [DATA_W*(i+1)-1 : DATA_W*i].
    function automatic int lane_lsb(input int lane);
        return lane * DATA_W;
    endfunction

    // Clamp a sign-extended sum into the DATA_W signed range.
    function automatic sat_res_t sat_to_dataw(input logic signed [SAT_IN_W-1:0] acc);
        sat_res_t r;
        if (acc > SAT_MAX) begin
            r.value = SAT_MAX[DATA_W-1:0];
            r.sat   = 1'b1;
        end else if (acc < SAT_MIN) begin
            r.value = SAT_MIN[DATA_W-1:0];
            r.sat   = 1'b1;
        end else begin
            r.value = acc[DATA_W-1:0];
            r.sat   = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/bias_accum_lane.sv
// -----------------------------------------------------------------------------
// bias_accum_lane
// One lane of the bias/accumulate stage: accumulator, bias add, clamp to
// DATA_W and (with BIAS_ACCUM_RELU_EN defined) ReLU on the clamped value.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_load        : accepted beat is the first of an output (acc = partial)
//   i_add         : accepted beat is a later one (acc += partial)
//   i_final       : register biased, saturated result this cycle
//   i_data        : signed partial sum for this lane
//   i_bias        : signed bias for this lane (only used when i_final)
//   o_data        : registered result, held between i_final strobes
//   o_sat         : registered flag, result was clamped
// Optional feature macro: BIAS_ACCUM_RELU_EN
// -----------------------------------------------------------------------------
module bias_accum_lane
    import bias_accum_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_add,
    input  logic              i_final,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_bias,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sat
);

    logic [ACC_W-1:0]           r_acc;
    logic [DATA_W-1:0]          r_out;
    logic                       r_sat;
    logic [ACC_W-1:0]           w_data_ext;
    logic [ACC_W:0]             w_sum;
    logic signed [SAT_IN_W-1:0] w_sum_ext;
    sat_res_t                   w_sat;
    logic [DATA_W-1:0]          w_out_val;

    assign w_data_ext = {{(ACC_W - DATA_W){i_data[DATA_W-1]}}, i_data};

    // One extra bit so acc + bias can never wrap before clamping.
    assign w_sum     = {r_acc[ACC_W-1], r_acc}
                     + {{(ACC_W + 1 - DATA_W){i_bias[DATA_W-1]}}, i_bias};
    assign w_sum_ext = {{(SAT_IN_W - ACC_W - 1){w_sum[ACC_W]}}, w_sum};
    assign w_sat     = sat_to_dataw(w_sum_ext);

    // Post-saturation value; ReLU only alters the value, never the flag.
    always_comb begin
        w_out_val = w_sat.value;
`ifdef BIAS_ACCUM_RELU_EN
        if (w_sat.value[DATA_W-1]) begin
            w_out_val = {DATA_W{1'b0}};
        end else begin
            w_out_val = w_sat.value;
        end
`else
        w_out_val = w_sat.value;
`endif
    end

    // Accumulator: first beat loads, later beats add, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= {ACC_W{1'b0}};
        end else if (i_load) begin
            r_acc <= w_data_ext;
        end else if (i_add) begin
            r_acc <= r_acc + w_data_ext;
        end else begin
            r_acc <= r_acc;
        end
    end

    // Result registers: written only in FINAL so they stay stable in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= {DATA_W{1'b0}};
            r_sat <= 1'b0;
        end else if (i_final) begin
            r_out <= w_out_val;
            r_sat <= w_sat.sat;
        end else begin
            r_out <= r_out;
            r_sat <= r_sat;
        end
    end

    assign o_data = r_out;
    assign o_sat  = r_sat;

endmodule

// File: rtl/bias_accum_stage.sv
// -----------------------------------------------------------------------------
// bias_accum_stage
// Accumulates N_PARTIAL partial-sum beats per output for N_adder_tree lanes,
// adds the per-lane bias, clamps to DATA_W signed and hands the result on
// over a valid/ready handshake.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : partial-sum beat present
//   in_ready   : stage accepts a beat (registered, high only in ACCUM)
//   in_data    : lane i at [DATA_W*(i+1)-1:DATA_W*i], signed
//   bias       : per-lane bias, same packing, sampled only in FINAL
//   out_valid  : result held valid (registered)
//   out_ready  : downstream accepts
//   out_data   : biased, saturated result, same packing
//   out_sat    : per-lane clamp flag for the current result
// Optional feature macro: BIAS_ACCUM_RELU_EN (negative results forced to 0)
// -----------------------------------------------------------------------------
module bias_accum_stage
    import bias_accum_pkg::*;
#(
    parameter int N_adder_tree = 16,
    parameter int N_PARTIAL    = 9,
    parameter int ACC_W        = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_adder_tree*DATA_W-1:0] in_data,
    input  logic [N_adder_tree*DATA_W-1:0] bias,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic [N_adder_tree-1:0]        out_sat
);

    localparam int CNT_W = (N_PARTIAL > 1) ? $clog2(N_PARTIAL) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PARTIAL - 1);

    generate
        if (ACC_W < DATA_W + $clog2(N_PARTIAL + 1)) begin : g_bad_acc_w
            $error("bias_accum_stage: ACC_W too small for N_PARTIAL");
        end
        if (N_PARTIAL < 1 || N_PARTIAL > 64) begin : g_bad_n_partial
            $error("bias_accum_stage: N_PARTIAL must be 1..64");
        end
    endgenerate

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_beat_xfer;
    logic             w_first_beat;
    logic             w_load;
    logic             w_add;
    logic             w_final;

    // in_ready is high exactly in ACCUM, so a transfer implies ACCUM.
    assign w_beat_xfer  = in_valid & r_in_ready;
    assign w_first_beat = (r_cnt == CNT_ZERO);
    assign w_load       = w_beat_xfer & w_first_beat;
    assign w_add        = w_beat_xfer & ~w_first_beat;
    assign w_final      = (r_state == ST_FINAL);

    // Stage FSM: beat counting, state sequencing and registered handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_cnt       <= CNT_ZERO;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_beat_xfer) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt      <= CNT_ZERO;
                            r_in_ready <= 1'b0;
                            r_state    <= ST_FINAL;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                ST_FINAL: begin
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Re-open the input only on the cycle after the result
                    // leaves; the single bubble keeps in_ready registered.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_cnt       <= CNT_ZERO;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_adder_tree; g = g + 1) begin : g_lane
            bias_accum_lane #(
                .ACC_W (ACC_W)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_load),
                .i_add   (w_add),
                .i_final (w_final),
                .i_data  (in_data[lane_lsb(g) +: DATA_W]),
                .i_bias  (bias[lane_lsb(g) +: DATA_W]),
                .o_data  (out_data[lane_lsb(g) +: DATA_W]),
                .o_sat   (out_sat[g])
            );
        end
    endgenerate

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bias_accum_stage.sv
// -----------------------------------------------------------------------------
// tb_bias_accum_stage
// Directed self-checking bench for bias_accum_stage (default parameters).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bias_accum_stage;

    localparam int NL = 16;
    localparam int DW = 18;
    localparam int NP = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [NL*DW-1:0]  in_data = '0;
    logic [NL*DW-1:0]  bias = '0;
    logic              in_ready;
    logic              out_valid;
    logic [NL*DW-1:0]  out_data;
    logic [NL-1:0]     out_sat;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint s0, s1, sr;   // model sums of lane0, lane1, lanes 2..15

    bias_accum_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic signed [63:0] lane_of(input logic [NL*DW-1:0] v, input int i);
        logic signed [DW-1:0] t;
        t = v[i*DW +: DW];
        return t;
    endfunction

    // Reference: bias add, clamp to 18-bit signed, optional ReLU.
    function automatic longint model_lane(input longint s, input longint b, output bit sat);
        longint t;
        t   = s + b;
        sat = 1'b0;
        if (t > 131071) begin
            t = 131071;  sat = 1'b1;
        end else if (t < -131072) begin
            t = -131072; sat = 1'b1;
        end
`ifdef BIAS_ACCUM_RELU_EN
        if (t < 0) t = 0;
`endif
        return t;
    endfunction

    task automatic set_bias(input longint x0, input longint x1);
        bias = '0;
        bias[0 +: DW]  = x0[DW-1:0];
        bias[DW +: DW] = x1[DW-1:0];
    endtask

    // Send n beats; beat j carries (v + j*step) per lane group. Ends on a
    // falling edge with in_valid low.
    task automatic feed(input longint v0, input longint v1, input longint vr,
                        input longint step, input bit bubbles, input int n);
        s0 = 0; s1 = 0; sr = 0;
        for (int j = 0; j < n; j++) begin
            int w;
            if (bubbles) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            for (int i = 0; i < NL; i++) begin
                longint v;
                v = ((i == 0) ? v0 : (i == 1) ? v1 : vr) + j * step;
                in_data[i*DW +: DW] = v[DW-1:0];
            end
            in_valid = 1'b1;
            w = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) check("beat_wait_timeout", in_ready, 1);
            @(posedge clk);
            s0 += v0 + j * step;
            s1 += v1 + j * step;
            sr += vr + j * step;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_out();
        int w;
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
    endtask

    task automatic check_result(input string tag, input longint b0, input longint b1);
        bit f0, f1, fr;
        longint e0, e1, er;
        logic [NL-1:0] esat;
        e0 = model_lane(s0, b0, f0);
        e1 = model_lane(s1, b1, f1);
        er = model_lane(sr, 0, fr);
        esat = {{(NL-2){fr}}, f1, f0};
        check({tag, "_lane0"},  lane_of(out_data, 0),  e0);
        check({tag, "_lane1"},  lane_of(out_data, 1),  e1);
        check({tag, "_lane2"},  lane_of(out_data, 2),  er);
        check({tag, "_lane15"}, lane_of(out_data, 15), er);
        check({tag, "_sat"},    {48'd0, out_sat},      {48'd0, esat});
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("accept_valid_drop", out_valid, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", (out_data == '0) ? 1 : 0, 1);
        check("rst_out_sat", {48'd0, out_sat}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic output and latency: 9*100+144=1044, 900-108=792
        set_bias(144, -108);
        feed(100, 100, 100, 0, 1'b0, NP);
        check("lat_final_valid", out_valid, 0);
        check("lat_final_ready", in_ready, 0);
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("basic_lane0_abs", lane_of(out_data, 0), 1044);
        check("basic_lane1_abs", lane_of(out_data, 1), 792);
        check_result("basic", 144, -108);
        accept();

        // Positive and negative overflow
        feed(131071, -131072, 0, 0, 1'b0, NP);
        wait_out();
        check("ovf_lane0_abs", lane_of(out_data, 0), 131071);
        check_result("ovf", 144, -108);
        accept();

        // Backpressure with in_valid held and bias changed during HOLD
        feed(50, -20, 7, 0, 1'b0, NP);
        wait_out();
        in_valid = 1'b1;
        in_data  = {NL{18'd5}};
        set_bias(999, 999);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check_result("bp_hold", 144, -108);
        end
        set_bias(144, -108);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_valid_drop", out_valid, 0);
        feed(1, 2, 3, 0, 1'b0, NP);
        wait_out();
        check("bp_next_lane0_abs", lane_of(out_data, 0), 153);
        check_result("bp_next", 144, -108);
        accept();

        // Bubbles on the input over three outputs, varying per-beat data
        for (int k = 0; k < 3; k++) begin
            feed(k * 1000 + 5, -k * 300, 17, k + 1, 1'b1, NP);
            wait_out();
            check_result("bubble", 144, -108);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept();
        end

        // Asynchronous reset after four beats
        feed(77, 77, 77, 0, 1'b0, 4);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_out_data", (out_data == '0) ? 1 : 0, 1);
        check("arst_out_sat", {48'd0, out_sat}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        feed(10, 10, 10, 0, 1'b0, NP);
        wait_out();
        check("arst_next_lane0_abs", lane_of(out_data, 0), 234);
        check_result("arst_next", 144, -108);
        accept();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
